// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register with load-use hazard detection.
//
// Moves one decoded instruction from ID into EX on each rising edge. When an
// instruction in ID needs the result of a load that is still in EX, stall_o
// asks upstream to hold PC and IF/ID, and a bubble goes into EX. A taken
// branch (flush_i) also puts a bubble into EX, and flush takes priority over
// the stall. bubble_cnt_o counts only the bubbles caused by hazards, and it
// stops at CNT_MAX.
//
// Ports
//   clk_i, rst_i                   clock; asynchronous active-low reset
//   rs1_i, rs2_i, rd_i             ID register indices
//   uses_rs1_i, uses_rs2_i         ID instruction really reads rs1 / rs2
//   rs1_data_i, rs2_data_i         ID operand values
//   imm_i, pc_i                    ID immediate and PC
//   reg_write_i .. branch_i        ID control bits
//   alu_op_i                       ID ALU operation class
//   id_valid_i                     ID slot holds a real instruction
//   flush_i                        kill the ID instruction (branch taken in EX)
//   ex_*_o                         registered EX-stage copies of the above
//   ex_valid_o                     EX slot holds a real instruction
//   stall_o                        combinational; hold PC and IF/ID this cycle
//   bubble_cnt_o                   hazard bubbles since reset, saturating

module id_ex_stage #(
    parameter int unsigned  DATA_W  = 32,
    // Value at which the bubble counter saturates.
    parameter logic [15:0]  CNT_MAX = 16'hFFFF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [4:0]        rd_i,
    input  logic              uses_rs1_i,
    input  logic              uses_rs2_i,
    input  logic [DATA_W-1:0] rs1_data_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic              reg_write_i,
    input  logic              mem_to_reg_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              alu_src_i,
    input  logic              branch_i,
    input  logic [1:0]        alu_op_i,
    input  logic              id_valid_i,
    input  logic              flush_i,
    output logic [4:0]        ex_rs1_o,
    output logic [4:0]        ex_rs2_o,
    output logic [4:0]        ex_rd_o,
    output logic [DATA_W-1:0] ex_rs1_data_o,
    output logic [DATA_W-1:0] ex_rs2_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [DATA_W-1:0] ex_pc_o,
    output logic              ex_reg_write_o,
    output logic              ex_mem_to_reg_o,
    output logic              ex_mem_read_o,
    output logic              ex_mem_write_o,
    output logic              ex_alu_src_o,
    output logic              ex_branch_o,
    output logic [1:0]        ex_alu_op_o,
    output logic              ex_valid_o,
    output logic              stall_o,
    output logic [15:0]       bubble_cnt_o
);

    logic rs1_hit;
    logic rs2_hit;
    logic hazard;
    logic load_id;

    // A bubble in EX has ex_valid_o = 0, so it can never cause a hazard.
    // A load therefore stalls the pipeline for at most one cycle.
    assign rs1_hit = uses_rs1_i && (rs1_i == ex_rd_o);
    assign rs2_hit = uses_rs2_i && (rs2_i == ex_rd_o);
    assign hazard  = ex_valid_o && ex_mem_read_o && (ex_rd_o != 5'd0) &&
                     id_valid_i && (rs1_hit || rs2_hit);
    assign stall_o = hazard && !flush_i;
    assign load_id = !(flush_i || hazard);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_rs1_o        <= '0;
            ex_rs2_o        <= '0;
            ex_rd_o         <= '0;
            ex_rs1_data_o   <= '0;
            ex_rs2_data_o   <= '0;
            ex_imm_o        <= '0;
            ex_pc_o         <= '0;
            ex_reg_write_o  <= 1'b0;
            ex_mem_to_reg_o <= 1'b0;
            ex_mem_read_o   <= 1'b0;
            ex_mem_write_o  <= 1'b0;
            ex_alu_src_o    <= 1'b0;
            ex_branch_o     <= 1'b0;
            ex_alu_op_o     <= '0;
            ex_valid_o      <= 1'b0;
            bubble_cnt_o    <= '0;
        end else begin
            // A bubble clears every field, so the EX contents stay all-zero
            // and deterministic whether the bubble comes from a flush or a hazard.
            ex_rs1_o        <= load_id ? rs1_i        : '0;
            ex_rs2_o        <= load_id ? rs2_i        : '0;
            ex_rd_o         <= load_id ? rd_i         : '0;
            ex_rs1_data_o   <= load_id ? rs1_data_i   : '0;
            ex_rs2_data_o   <= load_id ? rs2_data_i   : '0;
            ex_imm_o        <= load_id ? imm_i        : '0;
            ex_pc_o         <= load_id ? pc_i         : '0;
            ex_reg_write_o  <= load_id && reg_write_i;
            ex_mem_to_reg_o <= load_id && mem_to_reg_i;
            ex_mem_read_o   <= load_id && mem_read_i;
            ex_mem_write_o  <= load_id && mem_write_i;
            ex_alu_src_o    <= load_id && alu_src_i;
            ex_branch_o     <= load_id && branch_i;
            ex_alu_op_o     <= load_id ? alu_op_i     : '0;
            ex_valid_o      <= load_id && id_valid_i;
            if (stall_o && (bubble_cnt_o != CNT_MAX)) begin
                bubble_cnt_o <= bubble_cnt_o + 16'd1;
            end
        end
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width of register operands, immediate and PC.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports rs1_i, rs2_i, rd_i  input  5 each  ID-stage register indices (instr[19:15], [24:20], [11:7]).
REQ-005 SHALL have ports uses_rs1_i, uses_rs2_i  input  1 each  ID instruction actually reads rs1/rs2.
REQ-006 SHALL have ports rs1_data_i, rs2_data_i, imm_i, pc_i  input  DATA_W each  ID operands, immediate, PC.
REQ-007 SHALL have ports reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i, alu_src_i, branch_i  input  1 each  ID control.
REQ-008 SHALL have port alu_op_i  input  2  ID ALU operation class.
REQ-009 SHALL have port id_valid_i  input  1  ID slot holds a real instruction.
REQ-010 SHALL have port flush_i  input  1  branch taken in EX; kill ID instruction.
REQ-011 SHALL have ports ex_rs1_o, ex_rs2_o, ex_rd_o  output  5 each  registered indices feeding forwarding logic.
REQ-012 SHALL have ports ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_pc_o  output  DATA_W each  registered data.
REQ-013 SHALL have ports ex_reg_write_o, ex_mem_to_reg_o, ex_mem_read_o, ex_mem_write_o, ex_alu_src_o, ex_branch_o  output  1 each; ex_alu_op_o  output  2.
REQ-014 SHALL have port ex_valid_o  output  1  EX slot holds a real instruction.
REQ-015 SHALL have port stall_o  output  1  combinational; hold PC and IF/ID register this cycle.
REQ-016 SHALL have port bubble_cnt_o  output  16  count of bubbles inserted since reset.

Function
REQ-017 Load-use hazard SHALL be: ex_valid_o & ex_mem_read_o & (ex_rd_o!=0) & id_valid_i & ((uses_rs1_i & rs1_i==ex_rd_o) | (uses_rs2_i & rs2_i==ex_rd_o)).
REQ-018 stall_o SHALL equal hazard & !flush_i (flush overrides stall).
REQ-019 On flush_i=1 at an edge, EX SHALL load a bubble regardless of hazard.
REQ-020 On hazard & !flush_i at an edge, EX SHALL load a bubble; ID inputs are expected to be held by upstream and re-presented next cycle.
REQ-021 Otherwise EX SHALL load all ID inputs, with ex_valid_o <= id_valid_i.
REQ-022 Bubble SHALL mean: ex_valid_o=0, all control outputs and alu_op=0, indices=0, data/imm/pc=0.
REQ-023 Latency ID->EX SHALL be exactly one cycle; no combinational path from ID inputs to ex_* outputs.
REQ-024 A bubble SHALL never itself cause a hazard (ex_valid_o=0 gates REQ-017), so one load causes at most one stall cycle.
REQ-025 bubble_cnt_o SHALL increment by 1 on each edge loading a hazard bubble (REQ-020) and SHALL saturate at 16'hFFFF; flush bubbles SHALL NOT count.
REQ-026 id_valid_i=0 with no flush/hazard SHALL load inputs with ex_valid_o=0 and SHALL NOT increment bubble_cnt_o.
REQ-027 Writes with rd_i=0 SHALL be passed through unchanged; x0 filtering is downstream's job, except REQ-017 which ignores rd 0.

Reset
REQ-028 While rst_i=0, all ex_* outputs SHALL be 0, ex_valid_o=0, bubble_cnt_o=0, immediately (asynchronously).
REQ-029 stall_o SHALL be 0 during and after reset until a hazard per REQ-017 exists.
REQ-030 Reset asserted mid-stall SHALL clear state; after release the held ID instruction loads normally.

Verification
REQ-031 Load x5 in EX (mem_read=1, rd=5, valid), ID add uses rs1=5 -> stall_o=1; next edge ex_valid_o=0, bubble_cnt_o=1; following edge add enters EX, stall_o=0.
REQ-032 Same as REQ-031 but flush_i=1 -> stall_o=0; next edge bubble, bubble_cnt_o stays 0.
REQ-033 Load rd=0 in EX, ID rs2=0 with uses_rs2_i=1 -> stall_o=0, instruction passes in one cycle.
REQ-034 Load rd=7, ID rs2=7 but uses_rs2_i=0 (I-type) -> no stall; non-load (mem_read=0) rd=7 matching rs1 -> no stall.
REQ-035 Force 65536 consecutive load-use hazards -> bubble_cnt_o holds 16'hFFFF.
REQ-036 Pull rst_i low between edges while stall_o=1 -> outputs clear without clock edge; after release stall_o=0 and bubble_cnt_o=0.
